// File: rtl/enc_pkg.sv
// Shared types and quadrature decode helpers for the encoder line trigger.
package enc_pkg;

   typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;

   // Forward Gray sequence as {A,B}: A leads B.
   localparam logic [1:0] AB_S0 = 2'b00;
   localparam logic [1:0] AB_S1 = 2'b10;
   localparam logic [1:0] AB_S2 = 2'b11;
   localparam logic [1:0] AB_S3 = 2'b01;

   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      logic [1:0] w_nxt;
      case (ab)
         AB_S0:   w_nxt = AB_S1;
         AB_S1:   w_nxt = AB_S2;
         AB_S2:   w_nxt = AB_S3;
         default: w_nxt = AB_S0;
      endcase
      return w_nxt;
   endfunction

   function automatic step_t decode_step(input logic [1:0] prev_ab,
                                         input logic [1:0] new_ab,
                                         input logic       x4);
      logic [1:0] w_diff;
      step_t      w_step;
      w_diff = prev_ab ^ new_ab;
      w_step = STEP_NONE;
      if (w_diff == 2'b11) begin
         w_step = STEP_ERR;
      end else if (w_diff != 2'b00) begin
         if (x4) begin
            w_step = (new_ab == fwd_next(prev_ab)) ? STEP_FWD : STEP_REV;
         end else if (!prev_ab[1] && new_ab[1]) begin
            w_step = new_ab[0] ? STEP_REV : STEP_FWD;
         end
      end
      return w_step;
   endfunction

endpackage

// File: rtl/enc_filter.sv
// Two-flop synchroniser plus stability filter; o_valid rises once the first
// trusted filtered value is available and stays set until reset.
module enc_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic i_raw,
   output logic o_filt,
   output logic o_valid
);

   localparam logic [3:0] FILT_M1 = 4'(FILT_LEN - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_last;
   logic       r_filt;
   logic       r_valid;
   logic [3:0] r_cnt;
   logic [2:0] r_warm;

   // r_warm keeps the reset-zeroed pipeline from being mistaken for a real level.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_last  <= 1'b0;
         r_filt  <= 1'b0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_warm  <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_last  <= r_sync2;
         r_warm  <= {r_warm[1:0], 1'b1};
         if (!r_warm[2] || (r_sync2 != r_last)) begin
            r_cnt <= '0;
         end else if (r_cnt != FILT_M1) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (r_warm[2] && (r_cnt == FILT_M1)) begin
            r_filt  <= r_last;
            r_valid <= 1'b1;
         end
      end
   end

   assign o_filt  = r_filt;
   assign o_valid = r_valid;

endmodule

// File: rtl/enc_line_trigger.sv
// Quadrature position counter that emits a line-start pulse every CFG_DIV
// counts in the scan direction, absorbing backlash before re-arming.
module enc_line_trigger
   import enc_pkg::*;
#(
   parameter int FILT_LEN = 4,
   parameter int POS_W    = 32,
   parameter int DIV_W    = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ENC_A,
   input  logic             ENC_B,
   input  logic             ENC_Z,
   input  logic             CFG_X4,
   input  logic             CFG_DIR,
   input  logic             CFG_ZCLR,
   input  logic [DIV_W-1:0] CFG_DIV,
   input  logic             CLR,
   input  logic             LINE_BUSY,
   output logic             LINE_TRIG,
   output logic [POS_W-1:0] POS,
   output logic             DIR,
   output logic             ERR_SEQ,
   output logic             OVERRUN,
   output logic [DIV_W-1:0] MISSED
);

   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   logic [2:0] w_raw;
   logic [2:0] w_filt;
   logic [2:0] w_valid;

   assign w_raw = {ENC_A, ENC_B, ENC_Z};

   for (genvar gi = 0; gi < 3; gi++) begin : g_filt
      enc_filter #(.FILT_LEN(FILT_LEN)) u_filt (
         .CLK    (CLK),
         .RST_N  (RST_N),
         .i_raw  (w_raw[gi]),
         .o_filt (w_filt[gi]),
         .o_valid(w_valid[gi])
      );
   end

   logic [1:0]       r_ab_prev;
   logic             r_ab_valid;
   logic             r_z_prev;
   logic             r_z_valid;
   logic [POS_W-1:0] r_pos;
   logic             r_dir;
   logic             r_err;
   logic             r_ovr;
   logic [DIV_W-1:0] r_missed;
   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] r_debt;
   logic             r_trig;

   step_t            w_step;
   logic             w_counted;
   logic             w_with;
   logic             w_z_rise;
   logic [DIV_W:0]   w_div_inc;
   logic             w_fire;

   always_comb begin
      w_step    = r_ab_valid ? decode_step(r_ab_prev, w_filt[2:1], CFG_X4) : STEP_NONE;
      w_counted = (w_step == STEP_FWD) || (w_step == STEP_REV);
      w_with    = ((w_step == STEP_FWD) && !CFG_DIR) || ((w_step == STEP_REV) && CFG_DIR);
      w_z_rise  = r_z_valid && w_filt[0] && !r_z_prev;
      w_div_inc = {1'b0, r_div_cnt} + {1'b0, DIV_ONE};
      // Greater-or-equal so a lowered divider fires on the next qualifying step.
      w_fire    = w_with && (r_debt == '0) && (CFG_DIV != '0) &&
                  (w_div_inc >= {1'b0, CFG_DIV});
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ab_prev  <= '0;
         r_ab_valid <= 1'b0;
         r_z_prev   <= 1'b0;
         r_z_valid  <= 1'b0;
         r_pos      <= '0;
         r_dir      <= 1'b0;
         r_err      <= 1'b0;
         r_ovr      <= 1'b0;
         r_missed   <= '0;
         r_div_cnt  <= '0;
         r_debt     <= '0;
         r_trig     <= 1'b0;
      end else begin
         r_trig    <= 1'b0;
         r_z_valid <= w_valid[0];
         r_z_prev  <= w_filt[0];
         if (&w_valid[2:1]) begin
            r_ab_valid <= 1'b1;
            r_ab_prev  <= w_filt[2:1];
         end
         if (CLR) begin
            r_pos     <= '0;
            r_div_cnt <= '0;
            r_debt    <= '0;
            r_err     <= 1'b0;
            r_ovr     <= 1'b0;
            r_missed  <= '0;
         end else begin
            if (w_step == STEP_ERR) begin
               r_err <= 1'b1;
            end
            if (CFG_ZCLR && w_z_rise) begin
               r_pos <= '0;
            end else if (w_step == STEP_FWD) begin
               r_pos <= r_pos + POS_ONE;
            end else if (w_step == STEP_REV) begin
               r_pos <= r_pos - POS_ONE;
            end
            if (w_counted) begin
               r_dir <= (w_step == STEP_REV);
               if (w_with) begin
                  if (r_debt != '0) begin
                     r_debt <= r_debt - DIV_ONE;
                  end else if (CFG_DIV != '0) begin
                     r_div_cnt <= w_fire ? '0 : w_div_inc[DIV_W-1:0];
                  end
               end else if (r_debt != '1) begin
                  r_debt <= r_debt + DIV_ONE;
               end
            end
            if (w_fire) begin
               if (LINE_BUSY) begin
                  r_ovr <= 1'b1;
                  if (r_missed != '1) begin
                     r_missed <= r_missed + DIV_ONE;
                  end
               end else begin
                  r_trig <= 1'b1;
               end
            end
         end
      end
   end

   assign LINE_TRIG = r_trig;
   assign POS       = r_pos;
   assign DIR       = r_dir;
   assign ERR_SEQ   = r_err;
   assign OVERRUN   = r_ovr;
   assign MISSED    = r_missed;

endmodule

// File: tb/tb_enc_line_trigger.sv
// Directed bench: stimulus pushes expected trigger events, a monitor pops them.
module tb_enc_line_trigger;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ENC_A, ENC_B, ENC_Z;
   logic        CFG_X4, CFG_DIR, CFG_ZCLR;
   logic [15:0] CFG_DIV;
   logic        CLR, LINE_BUSY;
   logic        LINE_TRIG;
   logic [31:0] POS;
   logic        DIR, ERR_SEQ, OVERRUN;
   logic [15:0] MISSED;

   enc_line_trigger #(.FILT_LEN(4), .POS_W(32), .DIV_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .ENC_A(ENC_A), .ENC_B(ENC_B), .ENC_Z(ENC_Z),
      .CFG_X4(CFG_X4), .CFG_DIR(CFG_DIR), .CFG_ZCLR(CFG_ZCLR), .CFG_DIV(CFG_DIV),
      .CLR(CLR), .LINE_BUSY(LINE_BUSY), .LINE_TRIG(LINE_TRIG), .POS(POS),
      .DIR(DIR), .ERR_SEQ(ERR_SEQ), .OVERRUN(OVERRUN), .MISSED(MISSED)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      int          cyc;
      logic [31:0] pos;
   } exp_t;
   exp_t sb[$];

   int n_chk  = 0;
   int n_fail = 0;
   logic [1:0] ab = 2'b00;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: every trigger must match the oldest expected event.
   always @(negedge CLK) begin
      if (RST_N === 1'b1 && LINE_TRIG === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_trig: got pulse at cycle %0d pos %0d, expected none", cyc, POS);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("trig_cycle", cyc, e.cyc);
            chk("trig_pos", POS, e.pos);
         end
      end
   end

   // One encoder edge, driven on a falling edge; trigger expected 1+7 edges later.
   task automatic do_step(input bit rev, input bit exp_trig, input int exp_pos);
      if (!rev) begin
         case (ab)
            2'b00: ab = 2'b10;
            2'b10: ab = 2'b11;
            2'b11: ab = 2'b01;
            default: ab = 2'b00;
         endcase
      end else begin
         case (ab)
            2'b00: ab = 2'b01;
            2'b01: ab = 2'b11;
            2'b11: ab = 2'b10;
            default: ab = 2'b00;
         endcase
      end
      ENC_A = ab[1];
      ENC_B = ab[0];
      if (exp_trig) sb.push_back('{cyc: cyc + 8, pos: 32'(exp_pos)});
      repeat (20) @(negedge CLK);
   endtask

   task automatic clr_pulse();
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0; ENC_A = 1'b0; ENC_B = 1'b0; ENC_Z = 1'b0;
      CFG_X4 = 1'b1; CFG_DIR = 1'b0; CFG_ZCLR = 1'b0; CFG_DIV = 16'd10;
      CLR = 1'b0; LINE_BUSY = 1'b0;
      repeat (5) @(negedge CLK);
      chk("rst_pos", POS, 0);
      chk("rst_trig", LINE_TRIG, 0);
      chk("rst_err", ERR_SEQ, 0);
      chk("rst_missed", MISSED, 0);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);

      // Forward X4 run, DIV=10
      for (int i = 0; i < 40; i++) do_step(1'b0, (i % 10) == 9, i + 1);
      chk("fwd_pos", POS, 40);
      chk("fwd_dir", DIR, 0);
      chk("fwd_sb_empty", sb.size(), 0);

      // Backlash, DIV=4
      CFG_DIV = 16'd4;
      clr_pulse();
      chk("clr_pos", POS, 0);
      for (int i = 0; i < 3; i++) do_step(1'b0, 1'b0, 0);
      for (int i = 0; i < 2; i++) do_step(1'b1, 1'b0, 0);
      chk("bl_dir_rev", DIR, 1);
      for (int i = 0; i < 2; i++) do_step(1'b0, 1'b0, 0);
      chk("bl_pos3", POS, 3);
      chk("bl_no_trig", sb.size(), 0);
      do_step(1'b0, 1'b1, 4);
      chk("bl_pos4", POS, 4);
      chk("bl_sb_empty", sb.size(), 0);

      // Glitch: 3-cycle pulse on A must be rejected
      ENC_A = 1'b1;
      repeat (3) @(negedge CLK);
      ENC_A = 1'b0;
      repeat (20) @(negedge CLK);
      chk("glitch_pos", POS, 4);
      chk("glitch_err", ERR_SEQ, 0);

      // Illegal step: A and B toggle together
      ab = 2'b11; ENC_A = 1'b1; ENC_B = 1'b1;
      repeat (20) @(negedge CLK);
      chk("illegal_err", ERR_SEQ, 1);
      chk("illegal_pos", POS, 4);

      // Busy collision, DIV=2
      CFG_DIV = 16'd2; LINE_BUSY = 1'b1;
      do_step(1'b0, 1'b0, 0);
      do_step(1'b0, 1'b0, 0);
      chk("busy_pos", POS, 6);
      chk("busy_overrun", OVERRUN, 1);
      chk("busy_missed", MISSED, 1);
      LINE_BUSY = 1'b0;
      clr_pulse();
      chk("clr2_pos", POS, 0);
      chk("clr2_overrun", OVERRUN, 0);
      chk("clr2_missed", MISSED, 0);
      chk("clr2_err", ERR_SEQ, 0);

      // X1 mode, DIV=5
      CFG_X4 = 1'b0; CFG_DIV = 16'd5;
      for (int i = 0; i < 40; i++)
         do_step(1'b0, (i % 4 == 0) && ((i / 4 + 1) % 5 == 0), i / 4 + 1);
      chk("x1_pos", POS, 10);
      chk("x1_sb_empty", sb.size(), 0);

      // Index clear
      CFG_ZCLR = 1'b1; ENC_Z = 1'b1;
      repeat (20) @(negedge CLK);
      chk("zclr_pos", POS, 0);
      ENC_Z = 1'b0;
      repeat (20) @(negedge CLK);

      // Mid-run reset with AB=11
      CFG_X4 = 1'b1;
      do_step(1'b0, 1'b0, 0);
      do_step(1'b0, 1'b0, 0);
      chk("pre_rst_pos", POS, 2);
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("mrst_pos", POS, 0);
      chk("mrst_dir", DIR, 0);
      chk("mrst_overrun", OVERRUN, 0);
      chk("mrst_trig", LINE_TRIG, 0);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      chk("mrst_first_uncounted", POS, 0);
      do_step(1'b0, 1'b0, 0);
      chk("mrst_next_pos", POS, 1);
      chk("mrst_next_dir", DIR, 0);

      repeat (10) @(negedge CLK);
      chk("final_sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
